mem_access_unit: RTL and testbench

Memory-stage load/store unit of the RISC-V pipeline; it sits directly upstream of the write-back multiplexer and produces that mux's `mem` input. It turns a load or store request from the execute stage into a single word-aligned data-memory transaction. The transaction uses a req/ready handshake, byte enables and a timeout. It returns byte, halfword or word load data, sign- or zero-extended, and holds the pipeline stalled until the access completes.

---
 rtl/mem_access_unit_if.sv | 32 +++
 rtl/mem_access_unit.sv | 97 +++++++++
 tb/tb_mem_access_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline request/response and data-memory bus of the load/store unit.
interface mem_access_unit_if;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] storeData;
    logic [31:0] memReadData;
    logic        memReady;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic [3:0]  memByteEnable;
    logic [31:0] loadData;
    logic        loadValid;
    logic        errorValid;
    logic [1:0]  errorCode;
    logic        stall;

    modport master (
        output memRead, memWrite, funct3, address, storeData, memReadData, memReady,
        input  memReq, memWe, memAddr, memWriteData, memByteEnable,
               loadData, loadValid, errorValid, errorCode, stall
    );

    modport slave (
        input  memRead, memWrite, funct3, address, storeData, memReadData, memReady,
        output memReq, memWe, memAddr, memWriteData, memByteEnable,
               loadData, loadValid, errorValid, errorCode, stall
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit; one word-aligned req/ready transaction per access,
// with lane steering, load extension, error/timeout reporting and pipeline stall.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input logic clk,
    input logic rst,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t      st;
    logic [CW-1:0] cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        load_q;
    logic        req, illegal, misalign;
    logic [3:0]  be;
    logic [31:0] wdata, lane, ext;

    assign req = bus.memRead | bus.memWrite;
    assign illegal = bus.memWrite ? !(bus.funct3 inside {3'b000, 3'b001, 3'b010})
                                  : !(bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign misalign = (bus.funct3[1:0] == 2'b01 && bus.address[0]) ||
                      (bus.funct3[1:0] == 2'b10 && bus.address[1:0] != 2'b00);
    assign be = bus.funct3[1:0] == 2'b00 ? 4'b0001 << bus.address[1:0] :
                bus.funct3[1:0] == 2'b01 ? (bus.address[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata = bus.funct3[1:0] == 2'b00 ? {4{bus.storeData[7:0]}} :
                   bus.funct3[1:0] == 2'b01 ? {2{bus.storeData[15:0]}} : bus.storeData;
    // Shift the addressed lane down to bit 0, then extend by access size
    assign lane = bus.memReadData >> {off_q, 3'b000};
    assign ext = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & lane[7]}}, lane[7:0]} :
                 f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & lane[15]}}, lane[15:0]} : lane;
    assign bus.stall = (st == IDLE && req) || st == WAIT;

    always_ff @(posedge clk) begin
        if (rst) begin
            st                <= IDLE;
            cnt               <= '0;
            f3_q              <= '0;
            off_q             <= '0;
            load_q            <= 1'b0;
            bus.memReq        <= 1'b0;
            bus.memWe         <= 1'b0;
            bus.memAddr       <= '0;
            bus.memWriteData  <= '0;
            bus.memByteEnable <= '0;
            bus.loadData      <= '0;
            bus.loadValid     <= 1'b0;
            bus.errorValid    <= 1'b0;
            bus.errorCode     <= '0;
        end else begin
            bus.loadValid  <= 1'b0;
            bus.errorValid <= 1'b0;
            case (st)
                IDLE: if (req) begin
                    if (illegal || misalign) begin
                        bus.errorCode  <= illegal ? 2'd2 : 2'd1;
                        bus.errorValid <= 1'b1;
                        st             <= DONE;
                    end else begin
                        bus.memReq        <= 1'b1;
                        bus.memWe         <= bus.memWrite;
                        bus.memAddr       <= {bus.address[31:2], 2'b00};
                        bus.memByteEnable <= be;
                        bus.memWriteData  <= wdata;
                        f3_q              <= bus.funct3;
                        off_q             <= bus.address[1:0];
                        load_q            <= !bus.memWrite;
                        cnt               <= '0;
                        st                <= WAIT;
                    end
                end
                WAIT: if (bus.memReady) begin
                    bus.memReq <= 1'b0;
                    st         <= DONE;
                    if (load_q) begin
                        bus.loadData  <= ext;
                        bus.loadValid <= 1'b1;
                    end
                end else if (cnt == LAST) begin
                    bus.memReq     <= 1'b0;
                    bus.loadData   <= '0;
                    bus.errorValid <= 1'b1;
                    bus.errorCode  <= 2'd3;
                    st             <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed test-plan accesses plus random accesses checked against a
// size/offset arithmetic reference model of the load/store unit.
module tb_mem_access_unit;
    localparam int TO = 16;

    logic clk = 0;
    logic rst = 1;
    int   n_assert = 0;
    int   n_fail = 0;
    logic [31:0] ld_model = 0;

    mem_access_unit_if bus();
    mem_access_unit #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sz(input logic [2:0] f);
        return f[1:0] == 2'b00 ? 1 : f[1:0] == 2'b01 ? 2 : 4;
    endfunction

    function automatic logic [1:0] ref_err(input logic wr, input logic [2:0] f, input logic [31:0] a);
        logic legal;
        legal = wr ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
        if (!legal) return 2'd2;
        if (int'(a % 4) % sz(f) != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f, input logic [31:0] a);
        return 4'(((1 << sz(f)) - 1) << int'(a % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f, input logic [31:0] d);
        if (sz(f) == 1) return {24'b0, d[7:0]} * 32'h01010101;
        if (sz(f) == 2) return {16'b0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] r);
        logic [31:0] v, mask;
        int bits;
        bits = 8 * sz(f);
        v = r >> (8 * int'(a % 4));
        if (bits == 32) return v;
        mask = (32'h1 << bits) - 1;
        v = v & mask;
        if (!f[2] && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic access(input logic rd, input logic wr, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rdat, input int dly);
        logic [1:0] e;
        int nst, nreq, waits;
        logic to;
        e = ref_err(wr, f, a);
        bus.memRead = rd;
        bus.memWrite = wr;
        bus.funct3 = f;
        bus.address = a;
        bus.storeData = sd;
        bus.memReadData = rdat;
        #1;
        chk("idle_req", {31'b0, bus.memReq}, 0);
        nst = int'(bus.stall);
        nreq = 0;
        waits = 0;
        to = 0;
        @(posedge clk);
        @(negedge clk);
        if (e == 2'd0) begin
            for (int k = 0; k < TO; k++) begin
                waits++;
                nst += int'(bus.stall);
                nreq += int'(bus.memReq);
                if (k == 0) begin
                    chk("mem_we", {31'b0, bus.memWe}, {31'b0, wr});
                    chk("mem_addr", bus.memAddr, a & ~32'h3);
                    chk("mem_be", {28'b0, bus.memByteEnable}, {28'b0, ref_be(f, a)});
                    if (wr) chk("mem_wdata", bus.memWriteData, ref_wdata(f, sd));
                end
                bus.memReady = (k == dly);
                @(posedge clk);
                @(negedge clk);
                bus.memReady = 0;
                if (k == dly) break;
            end
            to = dly >= TO;
            chk("req_cycles", nreq, waits);
            if (to) ld_model = 0;
            else if (!wr) ld_model = ref_load(f, a, rdat);
        end
        chk("stall_cycles", nst, e != 2'd0 ? 1 : 1 + waits);
        chk("done_stall", {31'b0, bus.stall}, 0);
        chk("done_req", {31'b0, bus.memReq}, 0);
        chk("done_lvalid", {31'b0, bus.loadValid}, {31'b0, e == 2'd0 && !to && !wr});
        chk("done_evalid", {31'b0, bus.errorValid}, {31'b0, e != 2'd0 || to});
        if (e != 2'd0 || to) chk("done_ecode", {30'b0, bus.errorCode}, to ? 32'd3 : {30'b0, e});
        chk("done_ldata", bus.loadData, ld_model);
        bus.memRead = 0;
        bus.memWrite = 0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_pulses", {30'b0, bus.loadValid, bus.errorValid}, 0);
        chk("idle_stall", {31'b0, bus.stall}, 0);
    endtask

    initial begin
        logic rd, wr;
        int dly;
        bus.memRead = 0;
        bus.memWrite = 0;
        bus.funct3 = 0;
        bus.address = 0;
        bus.storeData = 0;
        bus.memReadData = 0;
        bus.memReady = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, bus.memReq}, 0);
        chk("rst_ldata", bus.loadData, 0);
        chk("rst_pulses", {30'b0, bus.loadValid, bus.errorValid}, 0);
        rst = 0;
        @(negedge clk);

        access(1, 0, 3'b000, 32'h103, 0, 32'h80FF1234, 0);
        chk("lb_data", bus.loadData, 32'hFFFFFF80);
        access(1, 0, 3'b101, 32'h102, 0, 32'h80FF1234, 3);
        chk("lhu_data", bus.loadData, 32'h000080FF);
        access(0, 1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 0);
        chk("sb_keeps_ldata", bus.loadData, 32'h000080FF);
        access(1, 0, 3'b010, 32'h102, 0, 0, 0);
        access(0, 1, 3'b100, 32'h100, 0, 0, 0);
        access(1, 0, 3'b010, 32'h40, 0, 32'h12345678, TO);
        chk("timeout_ldata", bus.loadData, 0);

        // Reset in the second WAIT cycle of a load
        bus.memRead = 1;
        bus.funct3 = 3'b010;
        bus.address = 32'h40;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        bus.memRead = 0;
        @(posedge clk);
        @(negedge clk);
        chk("wrst_req", {31'b0, bus.memReq}, 0);
        chk("wrst_we_be", {27'b0, bus.memWe, bus.memByteEnable}, 0);
        chk("wrst_addr", bus.memAddr, 0);
        chk("wrst_wdata", bus.memWriteData, 0);
        chk("wrst_ldata", bus.loadData, 0);
        chk("wrst_flags", {28'b0, bus.loadValid, bus.errorValid, bus.errorCode}, 0);
        chk("wrst_stall", {31'b0, bus.stall}, 0);
        ld_model = 0;
        rst = 0;
        @(posedge clk);
        @(negedge clk);
        chk("wrst_nopulse", {30'b0, bus.loadValid, bus.errorValid}, 0);
        access(1, 0, 3'b010, 32'h80, 0, 32'hCAFEF00D, 0);
        chk("post_rst_lw", bus.loadData, 32'hCAFEF00D);

        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            dly = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 4));
            access(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, dly);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
